exe_stage_mdu: RTL and testbench
================================

# exe_stage_mdu

Parametrised execute stage: it replaces the single-cycle execute stage, sitting between ID and MEM on the valid/allow_in pipeline handshake. Beyond the ALU path it adds:
- a single-cycle multiplier;
- an iterative radix-2 divider with a multi-cycle stall;
- sub-word store lane and strobe generation for byte, half, word (and dword when DATA_W=64);
- misaligned-address detection that suppresses the memory access;
- a pipeline flush input.

It drives Data RAM and the bypass network.

## Interface
- DATA_W, 32: datapath width, either 32 or 64; strobe width SW=DATA_W/8.
- AW, 5: register-file write address width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it clears all state.
- flush  in  1  kills the instruction in this stage and any division in progress.
- id_to_exe_valid  in  1  ID holds a valid instruction.
- exe_allow_in  out  1  this stage accepts an instruction this cycle.
- in_pc  in  32  instruction PC.
- in_alu_op  in  12  ALU one-hot operation.
- in_kind  in  3  0=ALU, 1=MUL, 2=MULH, 3=MULHU, 4=DIV, 5=DIVU, 6=MOD, 7=MODU.
- in_src1, in_src2  in  DATA_W  operands.
- in_st_data  in  DATA_W  store data.
- in_mem_en, in_mem_we  in  1  memory access, and write when set.
- in_mem_size  in  2  0=B, 1=H, 2=W, 3=D; D is legal only when DATA_W=64.
- in_rf_we  in  1  register write enable.
- in_wdest  in  AW  destination register.
- mem_allow_in  in  1  MEM accepts an instruction.
- exe_to_mem_valid  out  1  an instruction is handed to MEM.
- out_pc, out_result, out_wdest, out_rf_we, out_mem_size, out_mem_en, out_ale  out  -  registered fields passed on to MEM.
- data_ram_en  out  1  memory request.
- data_ram_addr  out  DATA_W  memory address.
- data_ram_w_en  out  SW  byte write strobes.
- data_ram_w_data  out  DATA_W  write data.
- by_valid, by_ready, by_wdest, by_result  out  -  bypass outputs.

## Operation
**Stage register and handshake**
- exe_valid rule:
  - flush → 0;
  - otherwise, when exe_allow_in, exe_valid ← id_to_exe_valid.
- Input fields are latched when id_to_exe_valid & exe_allow_in & ~flush.
- exe_allow_in = ~exe_valid | (ready_go & mem_allow_in).
- exe_to_mem_valid = exe_valid & ready_go & ~flush.

**ready_go**
- For kinds 0–3: ready_go = 1.
- For kinds 4–7: ready_go = 1 only when the divider state is DONE.

**Result per kind**
- ALU: alu result. The existing alu module is instantiated.
- MUL: low DATA_W bits of the product.
- MULH: high DATA_W bits of the signed × signed product.
- MULHU: high DATA_W bits of the unsigned × unsigned product.
- DIV/DIVU: quotient. MOD/MODU: remainder.

**Divider state machine** (states IDLE, BUSY, DONE)
- IDLE → BUSY when exe_valid & kind≥4 & ~flush. On this transition:
  - the operand magnitudes and result signs are loaded;
  - cnt ← DATA_W.
- BUSY: one restoring shift/subtract per cycle and cnt decrements. At cnt==1 the next state is DONE, and the sign fix-up is applied when DONE is entered.
- DONE holds its result until mem_allow_in, then goes to IDLE.
- Any state → IDLE on flush.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (MIN / −1): quotient = MIN, remainder = 0.
- Both special cases take the full latency.

**Memory access**
- Address = ALU result.
- Misaligned (ale) when any of:
  - H with addr[0] set;
  - W with addr[1:0] ≠ 0;
  - D with addr[2:0] ≠ 0.
- data_ram_en = exe_valid & in_mem_en & ~ale & mem_allow_in & ~flush. This fires exactly once, in the handoff cycle.
- Strobes are gated by in_mem_we:
  - B: 1 << addr lane;
  - H: 2'b11 << (2·half-lane);
  - W: 4'hF << (4·word-lane);
  - D: all ones.
- Write data is replicated across lanes: B: {SW{byte}}; H: {SW/2{half}}; W: {SW/4{word}}.
- out_ale is passed to MEM for exception handling.

**Bypass**
- by_valid = exe_valid & in_rf_we.
- by_ready = by_valid & ready_go & kind-not-load. While by_ready=0, ID must stall on a matching register.

## Timing
- Reset values: exe_valid=0, FSM=IDLE, all field registers 0, exe_allow_in=1. All valid, enable and strobe outputs are 0.
- ALU and MUL kinds: one cycle in the stage when MEM is ready.
- Division latency: with entry as cycle 0, cycles 1..DATA_W are BUSY and DONE (ready_go=1) is cycle DATA_W+1. Occupancy is therefore DATA_W+2 cycles when MEM is ready.
- The result is held stable throughout DONE while MEM stalls.
- Simultaneous events:
  - flush together with id_to_exe_valid: the incoming instruction is dropped.
  - flush in DONE: no handoff occurs.
- Asynchronous reset mid-division: exe_valid, the FSM and cnt clear immediately.

## Structure
- Shared package (exe_pkg): kind codes, size codes, the SW derivation and the divider state encoding.
- Sub-module iter_div: a self-contained, parametrised (DATA_W) divider FSM with ports start, flush, sign, dividend, divisor, done, quotient, remainder.
- The multiplier, strobe logic and handshake stay at top level.

## Test plan
- ADD 3+4, with MEM ready → exe_to_mem_valid one cycle after entry, out_result=7, exe_allow_in held at 1.
- DIV −7/2, DATA_W=32 → quotient −3 with ready_go in cycle 33; MOD of the same operands gives −1; exe_allow_in=0 in cycles 0–32.
- DIVU 5/0 → quotient 0xFFFFFFFF; MOD −2^31/−1 → remainder 0 with full latency.
- Store B to addr 0x1003, data 0xAB → w_en=4'b1000, w_data=0xABABABAB. Store H to 0x1001 → ale=1, data_ram_en=0.
- Store W while mem_allow_in is low for 3 cycles → data_ram_en asserted in exactly one cycle.
- flush at BUSY cycle 10 → FSM IDLE next cycle, exe_valid=0, no handoff; a following ADD completes normally.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage with multiply/divide support.
package exe_pkg;

  typedef enum logic [2:0] {
    K_ALU   = 3'd0,
    K_MUL   = 3'd1,
    K_MULH  = 3'd2,
    K_MULHU = 3'd3,
    K_DIV   = 3'd4,
    K_DIVU  = 3'd5,
    K_MOD   = 3'd6,
    K_MODU  = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic int strobe_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic is_div_kind(input kind_e k);
    return (k >= K_DIV);
  endfunction

endpackage

// File: rtl/alu.sv
// One-hot ALU: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
module alu #(
  parameter int DATA_W = 32
) (
  input  logic [11:0]       alu_op,
  input  logic [DATA_W-1:0] alu_src1,
  input  logic [DATA_W-1:0] alu_src2,
  output logic [DATA_W-1:0] alu_result
);
  localparam int SHW = $clog2(DATA_W);

  logic [SHW-1:0]    sa;
  logic [DATA_W-1:0] add_r, sub_r, sll_r, srl_r, sra_r;
  logic              slt_r, sltu_r;

  assign sa     = alu_src2[SHW-1:0];
  assign add_r  = alu_src1 + alu_src2;
  assign sub_r  = alu_src1 - alu_src2;
  assign slt_r  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_r = alu_src1 < alu_src2;
  assign sll_r  = alu_src1 << sa;
  assign srl_r  = alu_src1 >> sa;
  assign sra_r  = DATA_W'($signed(alu_src1) >>> sa);

  always_comb begin
    alu_result = ({DATA_W{alu_op[0]}}  & add_r)
               | ({DATA_W{alu_op[1]}}  & sub_r)
               | ({DATA_W{alu_op[2]}}  & DATA_W'(slt_r))
               | ({DATA_W{alu_op[3]}}  & DATA_W'(sltu_r))
               | ({DATA_W{alu_op[4]}}  & (alu_src1 & alu_src2))
               | ({DATA_W{alu_op[5]}}  & ~(alu_src1 | alu_src2))
               | ({DATA_W{alu_op[6]}}  & (alu_src1 | alu_src2))
               | ({DATA_W{alu_op[7]}}  & (alu_src1 ^ alu_src2))
               | ({DATA_W{alu_op[8]}}  & sll_r)
               | ({DATA_W{alu_op[9]}}  & srl_r)
               | ({DATA_W{alu_op[10]}} & sra_r)
               | ({DATA_W{alu_op[11]}} & alu_src2);
  end

endmodule

// File: rtl/iter_div.sv
// Radix-2 restoring divider on operand magnitudes; signs are reapplied on entry to DONE.
module iter_div
  import exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic              ack,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CW = $clog2(DATA_W) + 1;

  div_state_e        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] q, r, d;
  logic              q_neg, r_neg;
  logic              a_neg, b_neg;
  logic [DATA_W:0]   r_sh, r_sub;
  logic [DATA_W-1:0] q_nx, r_nx;

  assign a_neg = sign & dividend[DATA_W-1];
  assign b_neg = sign & divisor[DATA_W-1];

  // q doubles as the dividend shift register; its MSB feeds the partial remainder
  always_comb begin
    r_sh  = {r, q[DATA_W-1]};
    r_sub = r_sh - {1'b0, d};
    q_nx  = {q[DATA_W-2:0], ~r_sub[DATA_W]};
    r_nx  = r_sub[DATA_W] ? r_sh[DATA_W-1:0] : r_sub[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (flush) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            q     <= a_neg ? -dividend : dividend;
            d     <= b_neg ? -divisor : divisor;
            r     <= '0;
            // a zero divisor keeps quotient all ones and remainder = dividend
            q_neg <= (a_neg ^ b_neg) & (divisor != '0);
            r_neg <= a_neg;
            cnt   <= CW'(DATA_W);
            state <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            q     <= q_neg ? -q_nx : q_nx;
            r     <= r_neg ? -r_nx : r_nx;
            state <= DIV_DONE;
          end else begin
            q <= q_nx;
            r <= r_nx;
          end
        end
        DIV_DONE: begin
          if (ack) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign done      = (state == DIV_DONE);
  assign quotient  = q;
  assign remainder = r;

endmodule

// File: rtl/exe_stage_mdu.sv
// Execute stage: ALU, single-cycle multiplier, iterative divider, store lane/strobe
// generation and misalignment detection on the valid/allow_in handshake.
module exe_stage_mdu
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        id_to_exe_valid,
  output logic                        exe_allow_in,
  input  logic [31:0]                 in_pc,
  input  logic [11:0]                 in_alu_op,
  input  logic [2:0]                  in_kind,
  input  logic [DATA_W-1:0]           in_src1,
  input  logic [DATA_W-1:0]           in_src2,
  input  logic [DATA_W-1:0]           in_st_data,
  input  logic                        in_mem_en,
  input  logic                        in_mem_we,
  input  logic [1:0]                  in_mem_size,
  input  logic                        in_rf_we,
  input  logic [AW-1:0]               in_wdest,
  input  logic                        mem_allow_in,
  output logic                        exe_to_mem_valid,
  output logic [31:0]                 out_pc,
  output logic [DATA_W-1:0]           out_result,
  output logic [AW-1:0]               out_wdest,
  output logic                        out_rf_we,
  output logic [1:0]                  out_mem_size,
  output logic                        out_mem_en,
  output logic                        out_ale,
  output logic                        data_ram_en,
  output logic [DATA_W-1:0]           data_ram_addr,
  output logic [strobe_w(DATA_W)-1:0] data_ram_w_en,
  output logic [DATA_W-1:0]           data_ram_w_data,
  output logic                        by_valid,
  output logic                        by_ready,
  output logic [AW-1:0]               by_wdest,
  output logic [DATA_W-1:0]           by_result
);
  localparam int SW = strobe_w(DATA_W);
  localparam int LB = $clog2(SW);
  localparam int PW = 2 * DATA_W;

  logic              exe_valid;
  logic [31:0]       pc_q;
  logic [11:0]       alu_op_q;
  kind_e             kind_q;
  logic [DATA_W-1:0] src1_q, src2_q, st_q;
  logic              mem_en_q, mem_we_q, rf_we_q;
  size_e             size_q;
  logic [AW-1:0]     wdest_q;

  logic              ready_go;
  logic              div_start, div_sign, div_done;
  logic [DATA_W-1:0] div_q, div_r;
  logic [DATA_W-1:0] alu_result, result;
  logic              mul_signed;
  logic [DATA_W:0]   mul_a, mul_b;
  logic [PW-1:0]     product;
  logic [LB-1:0]     lane;
  logic              misalign, ale;
  logic [SW-1:0]     strb;
  logic [DATA_W-1:0] wdata;

  assign exe_allow_in     = ~exe_valid | (ready_go & mem_allow_in);
  assign exe_to_mem_valid = exe_valid & ready_go & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exe_valid <= 1'b0;
    end else if (flush) begin
      exe_valid <= 1'b0;
    end else if (exe_allow_in) begin
      exe_valid <= id_to_exe_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      alu_op_q <= '0;
      kind_q   <= K_ALU;
      src1_q   <= '0;
      src2_q   <= '0;
      st_q     <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      size_q   <= SZ_B;
      rf_we_q  <= 1'b0;
      wdest_q  <= '0;
    end else if (id_to_exe_valid && exe_allow_in && !flush) begin
      pc_q     <= in_pc;
      alu_op_q <= in_alu_op;
      kind_q   <= kind_e'(in_kind);
      src1_q   <= in_src1;
      src2_q   <= in_src2;
      st_q     <= in_st_data;
      mem_en_q <= in_mem_en;
      mem_we_q <= in_mem_we;
      size_q   <= size_e'(in_mem_size);
      rf_we_q  <= in_rf_we;
      wdest_q  <= in_wdest;
    end
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op     (alu_op_q),
    .alu_src1   (src1_q),
    .alu_src2   (src2_q),
    .alu_result (alu_result)
  );

  // one (DATA_W+1)-bit signed multiplier serves both MULH and MULHU
  assign mul_signed = (kind_q == K_MULH);
  assign mul_a      = {mul_signed & src1_q[DATA_W-1], src1_q};
  assign mul_b      = {mul_signed & src2_q[DATA_W-1], src2_q};
  assign product    = PW'($signed(mul_a)) * PW'($signed(mul_b));

  assign div_sign  = (kind_q == K_DIV) || (kind_q == K_MOD);
  assign div_start = exe_valid & is_div_kind(kind_q) & ~flush;

  iter_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .flush     (flush),
    .ack       (mem_allow_in),
    .sign      (div_sign),
    .dividend  (src1_q),
    .divisor   (src2_q),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign ready_go = is_div_kind(kind_q) ? div_done : 1'b1;

  always_comb begin
    result = alu_result;
    unique case (kind_q)
      K_MUL:           result = product[DATA_W-1:0];
      K_MULH, K_MULHU: result = product[PW-1:DATA_W];
      K_DIV, K_DIVU:   result = div_q;
      K_MOD, K_MODU:   result = div_r;
      default:         result = alu_result;
    endcase
  end

  assign lane = alu_result[LB-1:0];

  always_comb begin
    misalign = 1'b0;
    strb     = '1;
    wdata    = st_q;
    unique case (size_q)
      SZ_B: begin
        strb  = SW'(1) << lane;
        wdata = {SW{st_q[7:0]}};
      end
      SZ_H: begin
        misalign = alu_result[0];
        strb     = SW'(2'b11) << (lane & ~LB'(1));
        wdata    = {(SW/2){st_q[15:0]}};
      end
      SZ_W: begin
        misalign = |alu_result[1:0];
        strb     = SW'(4'hF) << (lane & ~LB'(3));
        wdata    = {(SW/4){st_q[31:0]}};
      end
      default: begin
        misalign = |alu_result[2:0];
        strb     = '1;
        wdata    = st_q;
      end
    endcase
  end

  assign ale             = mem_en_q & misalign;
  assign data_ram_en     = exe_valid & mem_en_q & ~ale & mem_allow_in & ~flush;
  assign data_ram_addr   = alu_result;
  assign data_ram_w_en   = (mem_en_q & mem_we_q) ? strb : '0;
  assign data_ram_w_data = wdata;

  assign out_pc       = pc_q;
  assign out_result   = result;
  assign out_wdest    = wdest_q;
  assign out_rf_we    = rf_we_q;
  assign out_mem_size = size_q;
  assign out_mem_en   = mem_en_q;
  assign out_ale      = ale;

  assign by_valid  = exe_valid & rf_we_q;
  assign by_ready  = by_valid & ready_go & ~(mem_en_q & ~mem_we_q);
  assign by_wdest  = wdest_q;
  assign by_result = result;

endmodule

// File: tb/tb_exe_stage_mdu.sv
// Scoreboard bench for exe_stage_mdu: directed vectors, monitor checks every MEM handoff.
module tb_exe_stage_mdu;
  localparam int DATA_W = 32;
  localparam int AW     = 5;
  localparam int DIV_LAT = DATA_W + 1;

  localparam logic [2:0] KA = 3'd0, KMUL = 3'd1, KMULH = 3'd2, KMULHU = 3'd3;
  localparam logic [2:0] KD = 3'd4, KDU = 3'd5, KM = 3'd6, KMU = 3'd7;
  localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              id_to_exe_valid = 1'b0;
  logic              exe_allow_in;
  logic [31:0]       in_pc = '0;
  logic [11:0]       in_alu_op = '0;
  logic [2:0]        in_kind = '0;
  logic [DATA_W-1:0] in_src1 = '0, in_src2 = '0, in_st_data = '0;
  logic              in_mem_en = 1'b0, in_mem_we = 1'b0;
  logic [1:0]        in_mem_size = '0;
  logic              in_rf_we = 1'b0;
  logic [AW-1:0]     in_wdest = 5'd3;
  logic              mem_allow_in = 1'b1;
  logic              exe_to_mem_valid;
  logic [31:0]       out_pc;
  logic [DATA_W-1:0] out_result;
  logic [AW-1:0]     out_wdest;
  logic              out_rf_we;
  logic [1:0]        out_mem_size;
  logic              out_mem_en, out_ale;
  logic              data_ram_en;
  logic [DATA_W-1:0] data_ram_addr;
  logic [3:0]        data_ram_w_en;
  logic [DATA_W-1:0] data_ram_w_data;
  logic              by_valid, by_ready;
  logic [AW-1:0]     by_wdest;
  logic [DATA_W-1:0] by_result;

  exe_stage_mdu #(.DATA_W(DATA_W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_to_exe_valid(id_to_exe_valid), .exe_allow_in(exe_allow_in),
    .in_pc(in_pc), .in_alu_op(in_alu_op), .in_kind(in_kind),
    .in_src1(in_src1), .in_src2(in_src2), .in_st_data(in_st_data),
    .in_mem_en(in_mem_en), .in_mem_we(in_mem_we), .in_mem_size(in_mem_size),
    .in_rf_we(in_rf_we), .in_wdest(in_wdest), .mem_allow_in(mem_allow_in),
    .exe_to_mem_valid(exe_to_mem_valid), .out_pc(out_pc), .out_result(out_result),
    .out_wdest(out_wdest), .out_rf_we(out_rf_we), .out_mem_size(out_mem_size),
    .out_mem_en(out_mem_en), .out_ale(out_ale), .data_ram_en(data_ram_en),
    .data_ram_addr(data_ram_addr), .data_ram_w_en(data_ram_w_en),
    .data_ram_w_data(data_ram_w_data), .by_valid(by_valid), .by_ready(by_ready),
    .by_wdest(by_wdest), .by_result(by_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic        ale;
  } exp_t;

  typedef struct {
    logic [2:0]  k;
    logic [11:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pc_ctr  = 32'h1c00_0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every handoff to MEM must match the oldest expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && exe_to_mem_valid && mem_allow_in) begin
        if (sb.size() == 0) begin
          chk("mon_unexpected_handoff", {32'h0, out_pc}, 64'hffff_ffff_ffff_ffff);
        end else begin
          e = sb.pop_front();
          chk($sformatf("mon_result pc=%0h", e.pc), {32'h0, out_result}, {32'h0, e.res});
          chk($sformatf("mon_pc pc=%0h", e.pc), {32'h0, out_pc}, {32'h0, e.pc});
          chk($sformatf("mon_ale pc=%0h", e.pc), {63'h0, out_ale}, {63'h0, e.ale});
        end
      end
    end
  end

  task automatic send(input logic [2:0] k, input logic [11:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                      input logic men, input logic mwe, input logic [1:0] sz,
                      input logic rfwe, input logic [31:0] exp_res, input logic exp_ale,
                      input bit push);
    int n;
    pc_ctr      = pc_ctr + 32'd4;
    in_pc       = pc_ctr;
    in_kind     = k;
    in_alu_op   = op;
    in_src1     = a;
    in_src2     = b;
    in_st_data  = st;
    in_mem_en   = men;
    in_mem_we   = mwe;
    in_mem_size = sz;
    in_rf_we    = rfwe;
    id_to_exe_valid = 1'b1;
    if (push) sb.push_back('{pc_ctr, exp_res, exp_ale});
    n = 0;
    @(negedge clk);
    while (!exe_allow_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    id_to_exe_valid = 1'b0;
  endtask

  // Counts stage cycles from entry until the handoff to MEM
  task automatic run_to_handoff(input string nm, input int exp_lat);
    int  cyc;
    bit  got;
    bit  seen_allow;
    cyc = 0; got = 0; seen_allow = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      if (exe_to_mem_valid && mem_allow_in) begin
        got = 1;
        chk({nm, "_allow_at_handoff"}, {63'h0, exe_allow_in}, 64'd1);
      end else begin
        if (exe_allow_in) seen_allow = 1;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    chk({nm, "_latency"}, cyc, exp_lat);
    if (exp_lat > 0) chk({nm, "_allow_low_while_busy"}, {63'h0, seen_allow}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[18];
  int   en_cnt;
  int   n;

  initial begin
    vecs = '{
      '{KA,     OP_ADD, 32'd3,        32'd4,        32'd7,        0},
      '{KA,     OP_SUB, 32'd3,        32'd4,        32'hFFFFFFFF, 0},
      '{KMUL,   12'h0,  32'd6,        32'd7,        32'd42,       0},
      '{KMUL,   12'h0,  32'h10000,    32'h10000,    32'h0,        0},
      '{KMULH,  12'h0,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0},
      '{KMULHU, 12'h0,  32'hFFFFFFFF, 32'd2,        32'h1,        0},
      '{KMULH,  12'h0,  32'h80000000, 32'h80000000, 32'h40000000, 0},
      '{KD,     12'h0,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT},
      '{KM,     12'h0,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT},
      '{KDU,    12'h0,  32'd5,        32'd0,        32'hFFFFFFFF, DIV_LAT},
      '{KM,     12'h0,  32'h80000000, 32'hFFFFFFFF, 32'h0,        DIV_LAT},
      '{KD,     12'h0,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT},
      '{KMU,    12'h0,  32'd5,        32'd0,        32'd5,        DIV_LAT},
      '{KD,     12'h0,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT},
      '{KM,     12'h0,  32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT},
      '{KDU,    12'h0,  32'd100,      32'd7,        32'd14,       DIV_LAT},
      '{KMU,    12'h0,  32'hFFFFFFFF, 32'd16,       32'd15,       DIV_LAT},
      '{KM,     12'h0,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, DIV_LAT}
    };

    // Reset state
    #12;
    chk("rst_allow_in",  {63'h0, exe_allow_in},     64'd1);
    chk("rst_to_mem",    {63'h0, exe_to_mem_valid}, 64'd0);
    chk("rst_ram_en",    {63'h0, data_ram_en},      64'd0);
    chk("rst_w_en",      {60'h0, data_ram_w_en},    64'd0);
    chk("rst_by_valid",  {63'h0, by_valid},         64'd0);
    chk("rst_by_ready",  {63'h0, by_ready},         64'd0);
    chk("rst_result",    {32'h0, out_result},       64'd0);
    chk("rst_ale",       {63'h0, out_ale},          64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Arithmetic vectors
    foreach (vecs[i]) begin
      send(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].b, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1,
           vecs[i].exp, 1'b0, 1'b1);
      run_to_handoff($sformatf("vec%0d", i), vecs[i].lat);
    end

    // Store byte to 0x1003
    send(KA, OP_ADD, 32'h1000, 32'h3, 32'hAB, 1'b1, 1'b1, 2'd0, 1'b0, 32'h1003, 1'b0, 1'b1);
    @(negedge clk);
    chk("sb_ram_en",  {63'h0, data_ram_en},     64'd1);
    chk("sb_w_en",    {60'h0, data_ram_w_en},   64'h8);
    chk("sb_w_data",  {32'h0, data_ram_w_data}, 64'hABABABAB);
    chk("sb_addr",    {32'h0, data_ram_addr},   64'h1003);
    @(posedge clk);
    #1;

    // Misaligned half store
    send(KA, OP_ADD, 32'h1000, 32'h1, 32'h1234, 1'b1, 1'b1, 2'd1, 1'b0, 32'h1001, 1'b1, 1'b1);
    @(negedge clk);
    chk("sh_mis_ram_en", {63'h0, data_ram_en},      64'd0);
    chk("sh_mis_ale",    {63'h0, out_ale},          64'd1);
    chk("sh_mis_to_mem", {63'h0, exe_to_mem_valid}, 64'd1);
    @(posedge clk);
    #1;

    // Aligned half store, upper lane
    send(KA, OP_ADD, 32'h1000, 32'h2, 32'h56781234, 1'b1, 1'b1, 2'd1, 1'b0, 32'h1002, 1'b0, 1'b1);
    @(negedge clk);
    chk("sh_ram_en", {63'h0, data_ram_en},     64'd1);
    chk("sh_w_en",   {60'h0, data_ram_w_en},   64'hC);
    chk("sh_w_data", {32'h0, data_ram_w_data}, 64'h12341234);
    @(posedge clk);
    #1;

    // Word load: not bypass-ready, no strobes
    send(KA, OP_ADD, 32'h2000, 32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b1, 32'h2000, 1'b0, 1'b1);
    @(negedge clk);
    chk("lw_ram_en",   {63'h0, data_ram_en},   64'd1);
    chk("lw_w_en",     {60'h0, data_ram_w_en}, 64'h0);
    chk("lw_by_valid", {63'h0, by_valid},      64'd1);
    chk("lw_by_ready", {63'h0, by_ready},      64'd0);
    chk("lw_by_wdest", {59'h0, by_wdest},      64'd3);
    @(posedge clk);
    #1;

    // Word store while MEM stalls for 3 cycles
    mem_allow_in = 1'b0;
    send(KA, OP_ADD, 32'h1000, 32'h4, 32'hDEADBEEF, 1'b1, 1'b1, 2'd2, 1'b0, 32'h1004, 1'b0, 1'b1);
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) mem_allow_in = 1'b1;
      @(negedge clk);
      if (data_ram_en) begin
        en_cnt++;
        chk("sw_stall_w_en",   {60'h0, data_ram_w_en},   64'hF);
        chk("sw_stall_w_data", {32'h0, data_ram_w_data}, 64'hDEADBEEF);
      end
      @(posedge clk);
      #1;
    end
    chk("sw_stall_en_count", en_cnt, 1);

    // Division result held in DONE while MEM stalls
    mem_allow_in = 1'b0;
    send(KDU, 12'h0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd14, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!exe_to_mem_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_ready_cycle", n, DIV_LAT);
    for (int i = 0; i < 3; i++) begin
      chk("hold_result",   {32'h0, out_result},   64'd14);
      chk("hold_allow_in", {63'h0, exe_allow_in}, 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    mem_allow_in = 1'b1;
    run_to_handoff("hold", 0);

    // Flush during BUSY cycle 10
    send(KD, 12'h0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd0, 1'b0, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("busy_by_valid", {63'h0, by_valid}, 64'd1);
    chk("busy_by_ready", {63'h0, by_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_to_mem", {63'h0, exe_to_mem_valid}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_allow_in", {63'h0, exe_allow_in}, 64'd1);
    chk("flush_by_valid", {63'h0, by_valid},     64'd0);
    @(posedge clk);
    #1;
    send(KA, OP_ADD, 32'd10, 32'd20, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd30, 1'b0, 1'b1);
    run_to_handoff("post_flush_add", 0);
    send(KD, 12'h0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd14, 1'b0, 1'b1);
    run_to_handoff("post_flush_div", DIV_LAT);

    // Flush together with an incoming instruction
    flush = 1'b1;
    in_kind = KA; in_alu_op = OP_ADD; in_src1 = 32'd1; in_src2 = 32'd1;
    in_mem_en = 1'b0; in_mem_we = 1'b0; in_rf_we = 1'b1;
    id_to_exe_valid = 1'b1;
    @(posedge clk);
    #1;
    id_to_exe_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_by_valid", {63'h0, by_valid},         64'd0);
    chk("flush_in_to_mem",   {63'h0, exe_to_mem_valid}, 64'd0);
    chk("flush_in_allow_in", {63'h0, exe_allow_in},     64'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-division
    send(KD, 12'h0, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd0, 1'b0, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst_allow_in", {63'h0, exe_allow_in},     64'd1);
    chk("arst_to_mem",   {63'h0, exe_to_mem_valid}, 64'd0);
    chk("arst_by_valid", {63'h0, by_valid},         64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(KA, OP_ADD, 32'd5, 32'd6, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd11, 1'b0, 1'b1);
    run_to_handoff("post_rst_add", 0);
    send(KDU, 12'h0, 32'd9, 32'd3, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd3, 1'b0, 1'b1);
    run_to_handoff("post_rst_div", DIV_LAT);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
